// File: rtl/monitor_baterias_pkg.sv
// Shared definitions for the battery monitor: per-channel state encoding and
// default parameter values.
package monitor_baterias_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ENTRANDO = 2'd1,
    BAJA     = 2'd2,
    SALIENDO = 2'd3
  } estado_t;

  localparam int unsigned N_BAT_DEF       = 2;
  localparam int unsigned ANCHO_DEF       = 4;
  localparam int unsigned UMBRAL_BAJO_DEF = 2;
  localparam int unsigned UMBRAL_ALTO_DEF = 4;
  localparam int unsigned FILTRO_DEF      = 3;

endpackage

// File: rtl/canal_bateria.sv
// One battery channel: debounced low-charge FSM with hysteresis, debounce
// counter and sticky alarm latch.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   i_habilitar   - 0 forces the FSM to NORMAL and clears the counter
//   i_muestra     - charge sample for this channel
//   i_ack         - clears the alarm (a simultaneous new warning wins)
//   o_adv_sig_c   - next-cycle warning value (registered by the top level)
//   o_alarma      - sticky alarm (registered)
module canal_bateria
  import monitor_baterias_pkg::*;
#(
  parameter int unsigned ANCHO       = ANCHO_DEF,
  parameter int unsigned UMBRAL_BAJO = UMBRAL_BAJO_DEF,
  parameter int unsigned UMBRAL_ALTO = UMBRAL_ALTO_DEF,
  parameter int unsigned FILTRO      = FILTRO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_habilitar,
  input  logic [ANCHO-1:0] i_muestra,
  input  logic             i_ack,
  output logic             o_adv_sig_c,
  output logic             o_alarma
);

  localparam int unsigned CW = $clog2(FILTRO + 1);
  localparam logic [CW-1:0]    FILTRO_C = CW'(FILTRO);
  localparam logic [ANCHO-1:0] BAJO_C   = ANCHO'(UMBRAL_BAJO);
  localparam logic [ANCHO-1:0] ALTO_C   = ANCHO'(UMBRAL_ALTO);
  localparam bit               DIRECTO  = (FILTRO == 1);

  estado_t       r_estado, w_estado_sig;
  logic [CW-1:0] r_cnt, w_cnt_sig;
  logic          r_alarma;
  logic          w_bajo, w_alto, w_entra_baja;

  assign w_bajo = (i_muestra <= BAJO_C);
  assign w_alto = (i_muestra >= ALTO_C);

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= NORMAL;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_cnt    <= w_cnt_sig;
    end
  end

  // Next-state and debounce counter; the counter is zero in the stable states
  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt;
    if (!i_habilitar) begin
      w_estado_sig = NORMAL;
      w_cnt_sig    = '0;
    end else begin
      case (r_estado)
        NORMAL: begin
          if (w_bajo) begin
            if (DIRECTO) begin
              w_estado_sig = BAJA;
              w_cnt_sig    = '0;
            end else begin
              w_estado_sig = ENTRANDO;
              w_cnt_sig    = CW'(1);
            end
          end
        end
        ENTRANDO: begin
          if (w_bajo) begin
            if (r_cnt + CW'(1) >= FILTRO_C) begin
              w_estado_sig = BAJA;
              w_cnt_sig    = '0;
            end else begin
              w_cnt_sig = r_cnt + CW'(1);
            end
          end else begin
            w_estado_sig = NORMAL;
            w_cnt_sig    = '0;
          end
        end
        BAJA: begin
          if (w_alto) begin
            if (DIRECTO) begin
              w_estado_sig = NORMAL;
              w_cnt_sig    = '0;
            end else begin
              w_estado_sig = SALIENDO;
              w_cnt_sig    = CW'(1);
            end
          end
        end
        SALIENDO: begin
          if (w_alto) begin
            if (r_cnt + CW'(1) >= FILTRO_C) begin
              w_estado_sig = NORMAL;
              w_cnt_sig    = '0;
            end else begin
              w_cnt_sig = r_cnt + CW'(1);
            end
          end else begin
            w_estado_sig = BAJA;
            w_cnt_sig    = '0;
          end
        end
        default: begin
          w_estado_sig = NORMAL;
          w_cnt_sig    = '0;
        end
      endcase
    end
  end

  // Outputs: a new warning is an entry into BAJA from outside the low region
  always_comb begin
    o_adv_sig_c  = (w_estado_sig == BAJA) || (w_estado_sig == SALIENDO);
    w_entra_baja = (w_estado_sig == BAJA) &&
                   ((r_estado == NORMAL) || (r_estado == ENTRANDO));
  end

  // Sticky alarm: set has priority over acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarma <= 1'b0;
    end else if (w_entra_baja) begin
      r_alarma <= 1'b1;
    end else if (i_ack) begin
      r_alarma <= 1'b0;
    end
  end

  assign o_alarma = r_alarma;

endmodule

// File: rtl/monitor_baterias.sv
// Multi-channel battery charge monitor.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   habilitar         - monitoring enable
//   carga             - packed samples, channel i at [i*ANCHO +: ANCHO]
//   ack               - per-channel alarm acknowledge
//   advertencia       - debounced low-charge warning per channel
//   descargada        - sample was zero on the previous edge
//   alarma            - sticky alarm per channel
//   num_advertencias  - number of warnings currently set
module monitor_baterias
  import monitor_baterias_pkg::*;
#(
  parameter int unsigned N_BAT       = N_BAT_DEF,
  parameter int unsigned ANCHO       = ANCHO_DEF,
  parameter int unsigned UMBRAL_BAJO = UMBRAL_BAJO_DEF,
  parameter int unsigned UMBRAL_ALTO = UMBRAL_ALTO_DEF,
  parameter int unsigned FILTRO      = FILTRO_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         habilitar,
  input  logic [N_BAT*ANCHO-1:0]       carga,
  input  logic [N_BAT-1:0]             ack,
  output logic [N_BAT-1:0]             advertencia,
  output logic [N_BAT-1:0]             descargada,
  output logic [N_BAT-1:0]             alarma,
  output logic [$clog2(N_BAT+1)-1:0]   num_advertencias
);

  localparam int unsigned NW = $clog2(N_BAT + 1);

  logic [N_BAT-1:0] w_adv_sig;
  logic [N_BAT-1:0] w_desc_sig;
  logic [NW-1:0]    w_num_sig;
  logic [N_BAT-1:0] r_adv;
  logic [N_BAT-1:0] r_desc;
  logic [NW-1:0]    r_num;

  for (genvar i = 0; i < N_BAT; i++) begin : g_canal
    logic [ANCHO-1:0] w_muestra;
    assign w_muestra     = carga[i*ANCHO +: ANCHO];
    assign w_desc_sig[i] = (w_muestra == '0);

    canal_bateria #(
      .ANCHO       (ANCHO),
      .UMBRAL_BAJO (UMBRAL_BAJO),
      .UMBRAL_ALTO (UMBRAL_ALTO),
      .FILTRO      (FILTRO)
    ) u_canal (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_habilitar (habilitar),
      .i_muestra   (w_muestra),
      .i_ack       (ack[i]),
      .o_adv_sig_c (w_adv_sig[i]),
      .o_alarma    (alarma[i])
    );
  end

  // Popcount of the next warning vector so the count lands with advertencia
  always_comb begin
    w_num_sig = '0;
    for (int i = 0; i < N_BAT; i++) begin
      w_num_sig = w_num_sig + NW'(w_adv_sig[i]);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adv  <= '0;
      r_desc <= '0;
      r_num  <= '0;
    end else begin
      r_adv  <= w_adv_sig;
      r_desc <= w_desc_sig;
      r_num  <= w_num_sig;
    end
  end

  assign advertencia      = r_adv;
  assign descargada       = r_desc;
  assign num_advertencias = r_num;

endmodule

// File: tb/tb_monitor_baterias.sv
// Directed bench for monitor_baterias with default parameters.
module tb_monitor_baterias;

  logic       clk;
  logic       rst_n;
  logic       habilitar;
  logic [7:0] carga;
  logic [1:0] ack;
  logic [1:0] advertencia;
  logic [1:0] descargada;
  logic [1:0] alarma;
  logic [1:0] num_advertencias;

  int checks;
  int errors;

  monitor_baterias dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .habilitar        (habilitar),
    .carga            (carga),
    .ack              (ack),
    .advertencia      (advertencia),
    .descargada       (descargada),
    .alarma           (alarma),
    .num_advertencias (num_advertencias)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    habilitar = 1'b1;
    carga     = 8'h00;
    ack       = 2'b00;

    // Reset holds everything at zero even across edges
    step();
    step();
    chk("rst_adv",  32'(advertencia), 32'h0);
    chk("rst_desc", 32'(descargada), 32'h0);
    chk("rst_alm",  32'(alarma), 32'h0);
    chk("rst_num",  32'(num_advertencias), 32'h0);

    rst_n = 1'b1;
    step();
    chk("rel_desc", 32'(descargada), 32'h3);
    chk("rel_adv",  32'(advertencia), 32'h0);

    // Both channels back to NORMAL
    carga = 8'h66;
    step();
    chk("hi_desc", 32'(descargada), 32'h0);

    // Debounce on ch0: three low samples
    carga = 8'h61;
    step();
    chk("deb_e1", 32'(advertencia), 32'h0);
    step();
    chk("deb_e2", 32'(advertencia), 32'h0);
    step();
    chk("deb_adv", 32'(advertencia), 32'h1);
    chk("deb_alm", 32'(alarma), 32'h1);
    chk("deb_num", 32'(num_advertencias), 32'h1);

    // Glitch on ch1: two low samples then high
    carga = 8'h21;
    step();
    chk("gl_e1", 32'(advertencia), 32'h1);
    step();
    chk("gl_e2", 32'(advertencia), 32'h1);
    chk("gl_alm2", 32'(alarma), 32'h1);
    carga = 8'h61;
    step();
    chk("gl_e3", 32'(advertencia), 32'h1);
    step();
    chk("gl_e4", 32'(advertencia), 32'h1);
    chk("gl_alm4", 32'(alarma), 32'h1);

    // Hysteresis band keeps ch0 low
    carga = 8'h63;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hys_band", 32'(advertencia), 32'h1);
    end
    carga = 8'h64;
    step();
    chk("rec_e1", 32'(advertencia), 32'h1);
    step();
    chk("rec_e2", 32'(advertencia), 32'h1);
    step();
    chk("rec_e3", 32'(advertencia), 32'h0);
    chk("rec_num", 32'(num_advertencias), 32'h0);
    chk("rec_alm", 32'(alarma), 32'h1);

    // Re-enter BAJA, then a short recovery burst
    carga = 8'h61;
    step();
    step();
    step();
    chk("reent_adv", 32'(advertencia), 32'h1);
    carga = 8'h64;
    step();
    chk("burst_e1", 32'(advertencia), 32'h1);
    step();
    chk("burst_e2", 32'(advertencia), 32'h1);
    carga = 8'h63;
    step();
    chk("burst_e3", 32'(advertencia), 32'h1);
    step();
    chk("burst_e4", 32'(advertencia), 32'h1);

    // Plain acknowledge, then ack on an already-clear alarm
    ack = 2'b01;
    step();
    chk("ack_clr", 32'(alarma), 32'h0);
    ack = 2'b10;
    step();
    chk("ack_noop", 32'(alarma), 32'h0);
    ack = 2'b00;

    // Ack race: recover, raise alarm, recover, re-enter with ack
    carga = 8'h64;
    step(); step(); step();
    chk("race_norm", 32'(advertencia), 32'h0);
    carga = 8'h61;
    step(); step(); step();
    chk("race_alm1", 32'(alarma), 32'h1);
    carga = 8'h64;
    step(); step(); step();
    chk("race_norm2", 32'(advertencia), 32'h0);
    chk("race_alm2", 32'(alarma), 32'h1);
    carga = 8'h61;
    step(); step();
    ack = 2'b01;
    step();
    chk("race_adv", 32'(advertencia), 32'h1);
    chk("race_win", 32'(alarma), 32'h1);
    step();
    chk("race_ack", 32'(alarma), 32'h0);
    ack = 2'b00;

    // Both channels low
    carga = 8'h11;
    step(); step(); step();
    chk("both_adv", 32'(advertencia), 32'h3);
    chk("both_num", 32'(num_advertencias), 32'h2);
    chk("both_alm", 32'(alarma), 32'h2);

    // Disable: FSMs cleared, alarm kept, descargada live
    habilitar = 1'b0;
    carga     = 8'h00;
    step();
    chk("dis_adv",  32'(advertencia), 32'h0);
    chk("dis_num",  32'(num_advertencias), 32'h0);
    chk("dis_alm",  32'(alarma), 32'h2);
    chk("dis_desc", 32'(descargada), 32'h3);
    ack = 2'b10;
    step();
    chk("dis_ack", 32'(alarma), 32'h0);
    ack = 2'b00;

    // Re-enable: count starts fresh
    habilitar = 1'b1;
    step();
    chk("en_e1", 32'(advertencia), 32'h0);
    step();
    chk("en_e2", 32'(advertencia), 32'h0);
    step();
    chk("en_e3", 32'(advertencia), 32'h3);
    chk("en_alm", 32'(alarma), 32'h3);
    chk("en_num", 32'(num_advertencias), 32'h2);

    // Async reset mid-ENTRANDO
    carga = 8'h66;
    step(); step(); step();
    chk("pre_norm", 32'(advertencia), 32'h0);
    carga = 8'h61;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_adv",  32'(advertencia), 32'h0);
    chk("arst_alm",  32'(alarma), 32'h0);
    chk("arst_desc", 32'(descargada), 32'h0);
    chk("arst_num",  32'(num_advertencias), 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_e1", 32'(advertencia), 32'h0);
    step();
    chk("post_e2", 32'(advertencia), 32'h0);
    step();
    chk("post_e3", 32'(advertencia), 32'h1);
    chk("post_alm", 32'(alarma), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
